// File: rtl/imem_access_arbiter_if.sv
// Bundles the signals between the instruction-ROM arbiter and its neighbours.
// The interface carries three groups of signals:
//   - the CPU fetch handshake: fetch_req, fetch_addr, fetch_rdata, fetch_done
//     and fetch_err;
//   - the APB debug slave port: PSEL, PENABLE, PWRITE, PADDR, PRDATA, PREADY
//     and PSLVERR;
//   - the ROM read port: rom_addr and rom_data.
// The slave modport is the arbiter's view. The master modport is the view of
// the surroundings: the CPU, the APB interconnect and the ROM.
interface imem_access_arbiter_if;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_rdata;
  logic        fetch_done;
  logic        fetch_err;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;

  modport slave (
    input  fetch_req, fetch_addr, PSEL, PENABLE, PWRITE, PADDR, rom_data,
    output fetch_rdata, fetch_done, fetch_err, PRDATA, PREADY, PSLVERR, rom_addr
  );

  modport master (
    output fetch_req, fetch_addr, PSEL, PENABLE, PWRITE, PADDR, rom_data,
    input  fetch_rdata, fetch_done, fetch_err, PRDATA, PREADY, PSLVERR, rom_addr
  );
endinterface

// File: rtl/imem_access_arbiter.sv
// Lets the CPU fetch stage and an APB debug port share one single-read-port
// instruction ROM. Only one access is in flight at a time.
// When both sides request at once, the grant goes round-robin: the side that
// was not granted last wins.
// A legal access waits RD_LATENCY cycles for the ROM data and then pulses the
// matching done/ready output for one cycle.
// Illegal accesses skip the ROM and respond with an error on the next cycle.
// An access is illegal if it is an APB write, or if its word index is at or
// beyond ROM_DEPTH.
// Ports:
//   clk   - rising-edge clock.
//   reset - synchronous, active-high reset.
//   bus   - slave modport carrying the fetch, APB and ROM signals.
module imem_access_arbiter #(
  parameter int unsigned ROM_DEPTH  = 256,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  imem_access_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic        last_apb;
  logic        grant_apb;
  logic [3:0]  count;

  logic        fetch_rq;
  logic        apb_rq;
  logic        pick_apb;
  logic        illegal;
  logic [31:0] sel_addr;

  // The APB setup phase is not a request. PREADY is masked so that the
  // completing access phase is not taken as a new request.
  always_comb begin
    fetch_rq = bus.fetch_req;
    apb_rq   = bus.PSEL & bus.PENABLE & ~bus.PREADY;
    pick_apb = apb_rq & (~fetch_rq | ~last_apb);
    sel_addr = pick_apb ? bus.PADDR : bus.fetch_addr;
    illegal  = (pick_apb & bus.PWRITE) | ({2'b00, sel_addr[31:2]} >= ROM_DEPTH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      last_apb        <= 1'b1;
      grant_apb       <= 1'b0;
      count           <= '0;
      bus.rom_addr    <= '0;
      bus.fetch_rdata <= '0;
      bus.fetch_done  <= 1'b0;
      bus.fetch_err   <= 1'b0;
      bus.PRDATA      <= '0;
      bus.PREADY      <= 1'b0;
      bus.PSLVERR     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fetch_rq | apb_rq) begin
            grant_apb <= pick_apb;
            last_apb  <= pick_apb;
            if (illegal) begin
              // Error path bypasses the ROM; rom_addr keeps its old value.
              if (pick_apb) begin
                bus.PRDATA  <= '0;
                bus.PREADY  <= 1'b1;
                bus.PSLVERR <= 1'b1;
              end else begin
                bus.fetch_rdata <= '0;
                bus.fetch_done  <= 1'b1;
                bus.fetch_err   <= 1'b1;
              end
              state <= RESP;
            end else begin
              bus.rom_addr <= {sel_addr[31:2], 2'b00};
              count        <= 4'(RD_LATENCY - 1);
              state        <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (count == '0) begin
            if (grant_apb) begin
              bus.PRDATA  <= bus.rom_data;
              bus.PREADY  <= 1'b1;
              bus.PSLVERR <= 1'b0;
            end else begin
              bus.fetch_rdata <= bus.rom_data;
              bus.fetch_done  <= 1'b1;
              bus.fetch_err   <= 1'b0;
            end
            state <= RESP;
          end else begin
            count <= count - 4'd1;
          end
        end
        RESP: begin
          bus.fetch_done <= 1'b0;
          bus.fetch_err  <= 1'b0;
          bus.PREADY     <= 1'b0;
          bus.PSLVERR    <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Directed, scoreboard-driven bench for imem_access_arbiter.
// dut1 uses RD_LATENCY=1 and dut3 uses RD_LATENCY=3; both have a 256-word ROM.
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled on
// the falling edge.
module tb_imem_access_arbiter;

  logic clk = 1'b0;
  logic rst1;
  logic rst3;
  always #5 clk = ~clk;

  imem_access_arbiter_if b1();
  imem_access_arbiter_if b3();

  logic [31:0] rom [256];
  assign b1.rom_data = rom[b1.rom_addr[9:2]];
  assign b3.rom_data = rom[b3.rom_addr[9:2]];

  imem_access_arbiter #(.ROM_DEPTH(256), .RD_LATENCY(1)) dut1 (
    .clk(clk), .reset(rst1), .bus(b1)
  );
  imem_access_arbiter #(.ROM_DEPTH(256), .RD_LATENCY(3)) dut3 (
    .clk(clk), .reset(rst3), .bus(b3)
  );

  typedef struct {
    bit          apb;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit apb, input logic [31:0] d, input logic e);
    exp_t x;
    x.apb  = apb;
    x.data = d;
    x.err  = e;
    sb.push_back(x);
  endtask

  // Compares one observed completion against the oldest scoreboard entry.
  task automatic score(input string tag, input bit apb_obs, input logic [31:0] d,
                       input logic e);
    exp_t x;
    chk({tag, " sb_pending"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk({tag, " side"}, 32'(apb_obs), 32'(x.apb));
      chk({tag, " data"}, d, x.data);
      chk({tag, " err"}, 32'(e), 32'(x.err));
    end
  endtask

  // Waits at most 40 falling edges for a completion pulse.
  // exp_lat is the index of the falling edge where the pulse is expected; the
  // first edge waited on is index 0.
  task automatic wait_resp(input bit d3, input int exp_lat, input string tag);
    bit seen;
    int k;
    logic fd;
    logic pr;
    seen = 1'b0;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      fd = d3 ? b3.fetch_done : b1.fetch_done;
      pr = d3 ? b3.PREADY : b1.PREADY;
      if (fd | pr) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, " completed"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, " latency"}, 32'(k), 32'(exp_lat));
      chk({tag, " one_side"}, 32'(fd & pr), 32'd0);
      if (pr)
        score(tag, 1'b1, d3 ? b3.PRDATA : b1.PRDATA, d3 ? b3.PSLVERR : b1.PSLVERR);
      else
        score(tag, 1'b0, d3 ? b3.fetch_rdata : b1.fetch_rdata,
              d3 ? b3.fetch_err : b1.fetch_err);
    end
  endtask

  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] d, input logic e,
                          input string tag);
    @(posedge clk); #1;
    b1.fetch_req  = 1'b1;
    b1.fetch_addr = addr;
    push(1'b0, d, e);
    wait_resp(1'b0, e ? 1 : 2, tag);
    b1.fetch_req = 1'b0;
    @(negedge clk);
    chk({tag, " done_pulse"}, 32'(b1.fetch_done), 32'd0);
  endtask

  task automatic do_apb(input logic [31:0] addr, input logic wr, input logic [31:0] d,
                        input logic e, input string tag);
    @(posedge clk); #1;
    b1.PSEL    = 1'b1;
    b1.PENABLE = 1'b0;
    b1.PWRITE  = wr;
    b1.PADDR   = addr;
    @(negedge clk);
    chk({tag, " setup_ready"}, 32'(b1.PREADY), 32'd0);
    @(posedge clk); #1;
    b1.PENABLE = 1'b1;
    push(1'b1, d, e);
    wait_resp(1'b0, e ? 1 : 2, tag);
    b1.PSEL    = 1'b0;
    b1.PENABLE = 1'b0;
    @(negedge clk);
    chk({tag, " ready_pulse"}, 32'(b1.PREADY), 32'd0);
  endtask

  logic [31:0] saved_addr;
  int          nf;
  int          na;
  int          both;
  bit          ack;

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'h1000_0000 + 32'(i) * 32'h0000_0101;
    rom[2] = 32'h0020_F0B3;
    rom[4] = 32'hDEAD_BEEF;
    {b1.fetch_req, b1.PSEL, b1.PENABLE, b1.PWRITE} = '0;
    {b3.fetch_req, b3.PSEL, b3.PENABLE, b3.PWRITE} = '0;
    b1.fetch_addr = '0; b1.PADDR = '0;
    b3.fetch_addr = '0; b3.PADDR = '0;
    rst1 = 1'b1;
    rst3 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset flags", 32'({b1.fetch_done, b1.fetch_err, b1.PREADY, b1.PSLVERR}), 32'd0);
    chk("reset fetch_rdata", b1.fetch_rdata, 32'd0);
    chk("reset PRDATA", b1.PRDATA, 32'd0);
    chk("reset rom_addr", b1.rom_addr, 32'd0);
    @(posedge clk); #1;
    rst1 = 1'b0;
    rst3 = 1'b0;

    // Basic fetch: rom_addr is visible in T+1 and the done pulse comes in T+2.
    @(posedge clk); #1;
    b1.fetch_req  = 1'b1;
    b1.fetch_addr = 32'h08;
    push(1'b0, 32'h0020_F0B3, 1'b0);
    @(negedge clk);
    chk("t1 done_T", 32'(b1.fetch_done), 32'd0);
    @(negedge clk);
    chk("t1 rom_addr", b1.rom_addr, 32'h08);
    chk("t1 done_T1", 32'(b1.fetch_done), 32'd0);
    wait_resp(1'b0, 0, "t1");
    b1.fetch_req = 1'b0;
    @(negedge clk);
    chk("t1 done_pulse", 32'(b1.fetch_done), 32'd0);

    do_apb(32'h13, 1'b0, 32'hDEAD_BEEF, 1'b0, "t2");

    // Both sides pending right after reset: fetch wins the first tie, then
    // grants alternate.
    @(posedge clk); #1;
    rst1 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    b1.PSEL = 1'b1; b1.PENABLE = 1'b0; b1.PWRITE = 1'b0; b1.PADDR = 32'h04;
    @(posedge clk); #1;
    b1.PENABLE = 1'b1;
    b1.fetch_req = 1'b1;
    b1.fetch_addr = 32'h00;
    push(1'b0, rom[0], 1'b0);
    push(1'b1, rom[1], 1'b0);
    push(1'b0, rom[0], 1'b0);
    push(1'b1, rom[1], 1'b0);
    nf = 0; na = 0; both = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      ack = 1'b0;
      if (b1.fetch_done & b1.PREADY) both++;
      if (b1.fetch_done | b1.PREADY) begin
        score("t3", b1.PREADY, b1.PREADY ? b1.PRDATA : b1.fetch_rdata,
              b1.PREADY ? b1.PSLVERR : b1.fetch_err);
        if (b1.PREADY) begin
          na++;
          ack = 1'b1;
        end else begin
          nf++;
        end
      end
      @(posedge clk); #1;
      if (ack) begin
        b1.PENABLE = 1'b0;
        if (na >= 2) b1.PSEL = 1'b0;
      end else if (b1.PSEL && !b1.PENABLE) begin
        b1.PENABLE = 1'b1;
      end
      if (nf >= 2) b1.fetch_req = 1'b0;
    end
    chk("t3 fetch_count", 32'(nf), 32'd2);
    chk("t3 apb_count", 32'(na), 32'd2);
    chk("t3 overlap", 32'(both), 32'd0);
    chk("t3 sb_drained", 32'(sb.size()), 32'd0);

    // Error responses: rom_addr must not move.
    saved_addr = b1.rom_addr;
    do_apb(32'h00, 1'b1, 32'h0, 1'b1, "t4");
    chk("t4 rom_addr", b1.rom_addr, saved_addr);
    do_fetch(32'h400, 32'h0, 1'b1, "t5");
    chk("t5 rom_addr", b1.rom_addr, saved_addr);
    do_fetch(32'h3FF, rom[255], 1'b0, "last_word");
    do_apb(32'h400, 1'b0, 32'h0, 1'b1, "apb_oor");

    // Reset in the second ACCESS cycle drops the access; the held fetch is
    // then served again from IDLE.
    @(posedge clk); #1;
    b3.fetch_req  = 1'b1;
    b3.fetch_addr = 32'h08;
    push(1'b0, 32'h0020_F0B3, 1'b0);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6 done_acc1", 32'(b3.fetch_done), 32'd0);
    @(posedge clk); #1;
    rst3 = 1'b1;
    @(negedge clk);
    chk("t6 done_acc2", 32'(b3.fetch_done), 32'd0);
    @(posedge clk); #1;
    rst3 = 1'b0;
    @(negedge clk);
    chk("t6 flags", 32'({b3.fetch_done, b3.fetch_err, b3.PREADY, b3.PSLVERR}), 32'd0);
    chk("t6 rom_addr", b3.rom_addr, 32'd0);
    chk("t6 fetch_rdata", b3.fetch_rdata, 32'd0);
    wait_resp(1'b1, 3, "t6");
    b3.fetch_req = 1'b0;
    @(negedge clk);
    chk("t6 done_pulse", 32'(b3.fetch_done), 32'd0);
    chk("final sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/imem_access_arbiter.md
Name: imem_access_arbiter

Overview:
- Shares the single-read-port instruction ROM between two requesters: the multi-cycle CPU fetch stage and an APB slave port used for debug readback of program memory.
- Sits between the CPU fetch path, the APB interconnect and the ROM.
- Serialises accesses with a small FSM, inserts a configurable wait for ROM read latency, arbitrates round-robin, and flags illegal or out-of-range accesses.

Parameters:
- ROM_DEPTH, 256, number of 32-bit words in the ROM. Valid word index is addr[31:2] < ROM_DEPTH.
- RD_LATENCY, 1, cycles the ROM data needs after rom_addr is stable. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- fetch_req  in  1  CPU fetch request; held high with a stable fetch_addr until fetch_done
- fetch_addr  in  32  byte address of the instruction
- fetch_rdata  out  32  instruction word, valid while fetch_done=1
- fetch_done  out  1  one-cycle completion pulse
- fetch_err  out  1  out-of-range fetch, valid with fetch_done
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PWRITE  in  1  APB direction; ROM is read-only
- PADDR  in  32  APB byte address
- PRDATA  out  32  APB read data
- PREADY  out  1  APB ready, one-cycle pulse
- PSLVERR  out  1  APB error, valid with PREADY
- rom_addr  out  32  registered byte address to the ROM
- rom_data  in  32  ROM read data

Behaviour:
- Reset: all outputs are 0, FSM goes to IDLE, last_grant=APB (so fetch wins the first tie), wait counter cleared. A reset mid-access drops the access: no done, PREADY or error pulse. A requester still holding its request is re-arbitrated from IDLE.
- Request definitions:
  - fetch request = fetch_req.
  - APB request = PSEL & PENABLE & ~PREADY. The setup phase is not a request.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - With no request, stay in IDLE.
  - With one request, grant it. With both, grant the requester that is not last_grant. Update last_grant on every grant.
  - On a legal grant: rom_addr <= {granted_addr[31:2], 2'b00}, counter <= RD_LATENCY-1, go to ACCESS.
  - On an illegal grant, do not touch rom_addr and go straight to RESP with error set. Illegal means: an APB access with PWRITE=1, or word index >= ROM_DEPTH for either requester.
- ACCESS: if counter==0, capture rom_data into the granted requester's data register and go to RESP; otherwise decrement the counter.
- RESP:
  - For a fetch grant: fetch_done=1 and fetch_err=error for exactly this cycle.
  - For an APB grant: PREADY=1 and PSLVERR=error for exactly this cycle.
  - Then return to IDLE.
- Error responses drive data = 0x0000_0000.
- Latency: a request seen in IDLE at cycle T completes in cycle T+RD_LATENCY+1, or in cycle T+1 for an error.
- Byte address bits [1:0] are ignored; misaligned addresses read the containing word.
- fetch_rdata and PRDATA hold their last value between accesses. They are sampled only with done/PREADY.
- Back-to-back:
  - If fetch_req is still high in the IDLE cycle after RESP, it is treated as a new fetch.
  - The APB master deasserts PENABLE after PREADY.
  - When both requesters are continuously pending, grants alternate strictly, so neither side starves.
- Only one access is outstanding at a time. No request is lost: an ungranted request stays pending until it is served.

Test Plan:
1. ROM word 2 = 0x0020F0B3, RD_LATENCY=1. Drive fetch_req=1, fetch_addr=0x08 at cycle T → rom_addr=0x08 from T+1; fetch_done=1 with fetch_rdata=0x0020F0B3 in T+2 only; fetch_err=0.
2. ROM word 4 = 0xDEADBEEF. Run an APB read of PADDR=0x13 (misaligned) → PREADY=1 one cycle after ACCESS, PRDATA=0xDEADBEEF, PSLVERR=0. PREADY is never high during the setup phase.
3. Right after reset, assert fetch (addr 0x00) and APB (addr 0x04) in the same cycle, and keep both pending → order of service is fetch, APB, fetch, APB. Each requester sees exactly one completion pulse per access.
4. APB write to 0x00 → PREADY=1 and PSLVERR=1 in the cycle after the grant, PRDATA=0, rom_addr unchanged.
5. ROM_DEPTH=256, fetch_addr=0x400 → fetch_done=1 with fetch_err=1 and fetch_rdata=0 at T+1; no ROM access.
6. RD_LATENCY=3; assert reset in the second ACCESS cycle → next cycle all outputs 0 and FSM in IDLE, no fetch_done. fetch_req held high after reset is re-served and completes 4 cycles after reset deasserts.
